// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multi-cycle RV32M multiply/divide unit:
// operation encodings, FSM state type and small op-decode helpers.
package muldiv_unit_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01001;
    localparam logic [4:0] OP_MULH   = 5'b01010;
    localparam logic [4:0] OP_MULHSU = 5'b01011;
    localparam logic [4:0] OP_MULHU  = 5'b01100;
    localparam logic [4:0] OP_DIV    = 5'b01101;
    localparam logic [4:0] OP_DIVU   = 5'b01110;
    localparam logic [4:0] OP_REM    = 5'b01111;
    localparam logic [4:0] OP_REMU   = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP
    } state_t;

    function automatic logic op_is_div(input logic [4:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_mul(input logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, subtract the divisor if it fits, emit the quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // rem_in < divisor, so a successful subtract always fits back in XLEN bits.
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Sequential RV32M multiply/divide unit: magnitude shift-add multiply and
// chained restoring divide, with a FIXUP cycle that applies result signs.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 4,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      select,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output state_t          state
);

    localparam int MB = MUL_BITS_PER_CYCLE;
    localparam int DB = DIV_BITS_PER_CYCLE;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_STEPS = CW'(XLEN / MB);
    localparam logic [CW-1:0] DIV_STEPS = CW'(XLEN / DB);

    // Handshake: start is sampled only while busy=0; busy rises after the
    // accepting edge and falls in the cycle where done pulses with result.
    logic [4:0]        op_q;
    logic              neg_q;
    logic              fast_q;
    logic [XLEN-1:0]   a_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic            s1, s2, is_div, is_valid, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, fast_val;

    always_comb begin
        s1       = (select inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && data1[XLEN-1];
        s2       = (select inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && data2[XLEN-1];
        mag1     = s1 ? -data1 : data1;
        mag2     = s2 ? -data2 : data2;
        is_div   = op_is_div(select);
        is_valid = is_div || op_is_mul(select);
        div_zero = is_div && (data2 == '0);
        div_ovf  = (select inside {OP_DIV, OP_REM}) &&
                   (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
        fast_val = '0;
        if (div_zero)
            fast_val = (select inside {OP_DIV, OP_DIVU}) ? '1 : data1;
        else if (div_ovf)
            fast_val = (select == OP_DIV) ? data1 : '0;
    end

    // Multiply: retire MB multiplier bits per cycle from the low half of acc.
    logic [XLEN+MB-1:0] pp, mul_sum;
    logic [2*XLEN-1:0]  mul_next;

    always_comb begin
        pp = '0;
        for (int i = 0; i < MB; i++)
            if (acc_q[i])
                pp = pp + ({{MB{1'b0}}, a_q} << i);
        mul_sum  = {{MB{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
        mul_next = {mul_sum, acc_q[XLEN-1:MB]};
    end

    // Divide: acc holds {remainder, dividend/quotient}, MSB-first.
    logic [XLEN-1:0]   rem_chain [DB+1];
    logic [DB-1:0]     qbits;
    logic [2*XLEN-1:0] div_next;

    assign rem_chain[0] = acc_q[2*XLEN-1:XLEN];

    for (genvar k = 0; k < DB; k++) begin : g_div
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in  (rem_chain[k]),
            .bit_in  (acc_q[XLEN-1-k]),
            .divisor (a_q),
            .rem_out (rem_chain[k+1]),
            .q_bit   (qbits[DB-1-k])
        );
    end

    assign div_next = {rem_chain[DB], acc_q[XLEN-1-DB:0], qbits};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_raw, rem_raw, fix_result;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_raw  = acc_q[XLEN-1:0];
        rem_raw  = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = neg_q ? -quo_raw : quo_raw;
            OP_REM, OP_REMU:               fix_result = neg_q ? -rem_raw : rem_raw;
            default:                       fix_result = '0;
        endcase
        if (fast_q)
            fix_result = acc_q[XLEN-1:0];
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            done   <= 1'b0;
            result <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            fast_q <= 1'b0;
            a_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q   <= select;
                        cnt_q  <= '0;
                        fast_q <= 1'b0;
                        // Fast paths park the counter at its limit so FIXUP follows next edge.
                        if (!is_valid || div_zero || div_ovf) begin
                            fast_q <= 1'b1;
                            neg_q  <= 1'b0;
                            acc_q  <= {{XLEN{1'b0}}, fast_val};
                            cnt_q  <= is_div ? DIV_STEPS : MUL_STEPS;
                            state  <= is_div ? ST_DIV : ST_MUL;
                        end else if (is_div) begin
                            a_q   <= mag2;
                            acc_q <= {{XLEN{1'b0}}, mag1};
                            neg_q <= (select inside {OP_DIV, OP_DIVU}) ? (s1 ^ s2) : s1;
                            state <= ST_DIV;
                        end else begin
                            a_q   <= mag1;
                            acc_q <= {{XLEN{1'b0}}, mag2};
                            neg_q <= s1 ^ s2;
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush)
                        state <= ST_IDLE;
                    else if (cnt_q == MUL_STEPS)
                        state <= ST_FIXUP;
                    else begin
                        acc_q <= mul_next;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DIV: begin
                    if (flush)
                        state <= ST_IDLE;
                    else if (cnt_q == DIV_STEPS)
                        state <= ST_FIXUP;
                    else begin
                        acc_q <= div_next;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_FIXUP: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        done   <= 1'b1;
                        result <= fix_result;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
